// File: rtl/vc_arbiter.sv
// Two-VC pop arbiter: strict VC0 priority, registered mux select/valid aligned to the FIFO pop delay.
// Optional starvation guard for VC1 enabled by defining VC_STARVE_GUARD_EN.
module vc_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vc0_empty,
  input  logic       vc1_empty,
  input  logic       dst_almost_full,
  output logic       pop_VC0,
  output logic       pop_VC1,
  output logic       selector,
  output logic       valid_out,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRV0  = 2'd1,
    SRV1  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   pop_ok;
  logic   starve_hit;

  assign pop_ok = !reset && !dst_almost_full;

`ifdef VC_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve_hit = (starve_cnt == STARVE_LIMIT[3:0]);

  // Counts VC0 grants taken while VC1 is waiting; saturates so it never wraps past the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (vc1_empty || pop_VC1) begin
      starve_cnt <= 4'd0;
    end else if (pop_VC0 && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    pop_VC0 = 1'b0;
    pop_VC1 = 1'b0;
    state_d = IDLE;
    if (pop_ok) begin
      if (starve_hit && !vc1_empty) begin
        pop_VC1 = 1'b1;
      end else if (!vc0_empty) begin
        pop_VC0 = 1'b1;
      end else if (!vc1_empty) begin
        pop_VC1 = 1'b1;
      end
    end
    if (dst_almost_full) begin
      state_d = PAUSE;
    end else if (pop_VC0) begin
      state_d = SRV0;
    end else if (pop_VC1) begin
      state_d = SRV1;
    end
  end

  // Select and valid follow the grant by one cycle, matching the FIFO read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      selector  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_out <= pop_VC0 || pop_VC1;
      if (pop_VC0) begin
        selector <= 1'b0;
      end else if (pop_VC1) begin
        selector <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive VC0 grants allowed while VC1 waits (guard enabled only; legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 vc0_empty  input  1  VC0 FIFO empty flag.
REQ-005 vc1_empty  input  1  VC1 FIFO empty flag.
REQ-006 dst_almost_full  input  1  downstream back-pressure; 1 = no new pops.
REQ-007 pop_VC0  output  1  combinational pop strobe to VC0 FIFO.
REQ-008 pop_VC1  output  1  combinational pop strobe to VC1 FIFO.
REQ-009 selector  output  1  registered mux select, 0 = VC0, 1 = VC1, aligned with popped data.
REQ-010 valid_out  output  1  registered; 1 = mux output this cycle carries a popped word.
REQ-011 state  output  2  registered FSM state for debug: IDLE=0, SRV0=1, SRV1=2, PAUSE=3.

Function
REQ-012 Grant decision SHALL be combinational each cycle; at most one of pop_VC0/pop_VC1 high per cycle.
REQ-013 No pop SHALL be issued while reset=1 or dst_almost_full=1, regardless of FIFO flags.
REQ-014 Base policy: strict priority; pop_VC0 = !vc0_empty when popping is allowed; pop_VC1 = vc0_empty && !vc1_empty.
REQ-015 A pop SHALL never be issued to an empty FIFO.
REQ-016 Latency: pop at cycle t -> valid_out=1 and selector = granted VC at cycle t+1, matching the FIFO's one-cycle pop delay.
REQ-017 With no pop at t, valid_out=0 at t+1 and selector SHALL hold its previous value.
REQ-018 FSM next state: dst_almost_full=1 -> PAUSE; else pop_VC0 -> SRV0; else pop_VC1 -> SRV1; else IDLE.
REQ-019 PAUSE exit SHALL occur the first cycle dst_almost_full=0, with a grant issued in that same cycle if either FIFO is non-empty (zero bubble).
REQ-020 Back-to-back pops SHALL be sustained every cycle; switching VC0<->VC1 SHALL add no idle cycle.
REQ-021 dst_almost_full rising in the same cycle as a would-be pop SHALL suppress that pop.

Reset
REQ-022 While reset=1 at a rising edge: selector=0, valid_out=0, state=IDLE, starvation counter=0.
REQ-023 Reset asserted mid-burst SHALL drop valid_out to 0 the cycle after the reset edge; no pop is issued during reset cycles.
REQ-024 The first grant after reset release SHALL occur in the first cycle with reset=0.

Configuration
REQ-025 Macro VC_STARVE_GUARD_EN: when defined, a 4-bit counter increments on each VC0 grant while vc1_empty=0, and clears on a VC1 grant or when vc1_empty=1.
REQ-026 With VC_STARVE_GUARD_EN defined and counter == STARVE_LIMIT, the next allowed grant SHALL go to VC1 if non-empty, overriding VC0 priority for exactly one grant.
REQ-027 With VC_STARVE_GUARD_EN undefined, no counter logic SHALL exist and the policy is pure strict priority (REQ-014).

Verification
REQ-028 Reset: hold reset=1 for 2 cycles with both FIFOs non-empty -> pops 0, selector=0, valid_out=0, state=0.
REQ-029 Priority: vc0_empty=0, vc1_empty=0, dst_almost_full=0, guard off -> pop_VC0=1 every cycle, selector=0, valid_out=1 from the second cycle.
REQ-030 Drain switch: VC0 holds 2 words, VC1 holds 3 -> pops VC0,VC0,VC1,VC1,VC1 on consecutive cycles; selector 0,0,1,1,1 one cycle later; then state=IDLE.
REQ-031 Back-pressure: dst_almost_full=1 for 3 cycles mid-stream -> no pops, state=3, valid_out=0 after one cycle; pop resumes the cycle the flag clears.
REQ-032 Starvation guard: macro on, STARVE_LIMIT=4, both FIFOs always non-empty -> grant pattern VC0 x4, VC1 x1, repeating.
REQ-033 Reset mid-burst: assert reset during a VC1 burst -> no pop in reset cycles, valid_out=0 and selector=0 the next cycle.
